// File: rtl/slot_game_ctrl_pkg.sv
// slot_game_ctrl_pkg: shared widths, FSM states, payout constants and credit arithmetic
package slot_game_ctrl_pkg;
  localparam int SYM_W = 4;
  localparam int CREDIT_W = 8;
  localparam int REELS = 3;
  localparam logic [SYM_W-1:0] FEVER_SYM = SYM_W'(7);
  localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(3);
  localparam logic [CREDIT_W-1:0] PAYOUT_SMALL = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] PAYOUT_BIG = CREDIT_W'(15);
  typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1, JUDGE = 2'd2} state_t;
  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a, input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CREDIT_W] ? '1 : s[CREDIT_W-1:0];
  endfunction
endpackage

// File: rtl/slot_game_ctrl_if.sv
// slot_game_ctrl_if: buttons and live reel symbols in, reel control and game status out
interface slot_game_ctrl_if;
  import slot_game_ctrl_pkg::*;
  logic start_pulse;
  logic [REELS-1:0] stop_pulse;
  logic [SYM_W-1:0] reel_sym0;
  logic [SYM_W-1:0] reel_sym1;
  logic [SYM_W-1:0] reel_sym2;
  logic [REELS-1:0] reel_run;
  logic master_state;
  logic fever;
  logic [CREDIT_W-1:0] credit;
  logic win;
  logic [REELS*SYM_W-1:0] stop_sym;
  modport master(
    output start_pulse, stop_pulse, reel_sym0, reel_sym1, reel_sym2,
    input reel_run, master_state, fever, credit, win, stop_sym
  );
  modport slave(
    input start_pulse, stop_pulse, reel_sym0, reel_sym1, reel_sym2,
    output reel_run, master_state, fever, credit, win, stop_sym
  );
endinterface

// File: rtl/slot_game_ctrl_fever_timer.sv
// slot_game_ctrl_fever_timer: reloadable down-counter whose nonzero state is the fever window
module slot_game_ctrl_fever_timer #(
  parameter int TMR_W = 24,
  parameter int FEVER_CYCLES = 12_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  output logic active
);
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  assign tmr_nxt = load ? TMR_W'(FEVER_CYCLES) : (tmr != '0 ? tmr - TMR_W'(1) : tmr);
  // reload takes priority over expiry so a back-to-back jackpot keeps fever high
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      tmr <= '0;
      active <= 1'b0;
    end else begin
      tmr <= tmr_nxt;
      active <= tmr_nxt != '0;
    end
endmodule

// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl: start/stop sequencing of three reels, judging, credits and fever window
module slot_game_ctrl
  import slot_game_ctrl_pkg::*;
#(
  parameter int TMR_W = 24,
  parameter int FEVER_CYCLES = 12_000_000
) (
  input logic clock,
  input logic reset_n,
  slot_game_ctrl_if.slave bus
);
  state_t state;
  state_t state_nxt;
  logic [REELS-1:0] run_nxt;
  logic ms_nxt;
  logic win_nxt;
  logic load;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [REELS*SYM_W-1:0] ss_nxt;
  logic [REELS*SYM_W-1:0] live;
  logic [REELS-1:0] hit;
  logic all_eq;
  logic big;
  assign live = {bus.reel_sym2, bus.reel_sym1, bus.reel_sym0};
  assign hit = bus.stop_pulse & bus.reel_run;
  assign all_eq = bus.stop_sym[0 +: SYM_W] == bus.stop_sym[SYM_W +: SYM_W]
               && bus.stop_sym[SYM_W +: SYM_W] == bus.stop_sym[2*SYM_W +: SYM_W];
  assign big = all_eq && bus.stop_sym[0 +: SYM_W] == FEVER_SYM;
  slot_game_ctrl_fever_timer #(.TMR_W(TMR_W), .FEVER_CYCLES(FEVER_CYCLES)) u_fever (
    .clock(clock),
    .reset_n(reset_n),
    .load(load),
    .active(bus.fever)
  );
  // next game state, reel latching and credit arithmetic
  always_comb begin
    state_nxt = state;
    run_nxt = bus.reel_run;
    ms_nxt = bus.master_state;
    win_nxt = 1'b0;
    load = 1'b0;
    credit_nxt = bus.credit;
    ss_nxt = bus.stop_sym;
    case (state)
      IDLE:
        if (bus.start_pulse && (bus.fever || bus.credit != '0)) begin
          state_nxt = SPIN;
          run_nxt = '1;
          ms_nxt = 1'b1;
          credit_nxt = bus.fever ? bus.credit : bus.credit - CREDIT_W'(1);
        end
      SPIN: begin
        for (int i = 0; i < REELS; i++)
          if (hit[i]) ss_nxt[i*SYM_W +: SYM_W] = live[i*SYM_W +: SYM_W];
        run_nxt = bus.reel_run & ~bus.stop_pulse;
        state_nxt = run_nxt == '0 ? JUDGE : SPIN;
      end
      JUDGE: begin
        state_nxt = IDLE;
        ms_nxt = 1'b0;
        win_nxt = all_eq;
        load = big;
        credit_nxt = all_eq ? sat_add(bus.credit, big ? PAYOUT_BIG : PAYOUT_SMALL) : bus.credit;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // all game outputs are registered
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      bus.reel_run <= '0;
      bus.master_state <= 1'b0;
      bus.win <= 1'b0;
      bus.credit <= CREDIT_INIT;
      bus.stop_sym <= '0;
    end else begin
      state <= state_nxt;
      bus.reel_run <= run_nxt;
      bus.master_state <= ms_nxt;
      bus.win <= win_nxt;
      bus.credit <= credit_nxt;
      bus.stop_sym <= ss_nxt;
    end
endmodule

// File: tb/tb_slot_game_ctrl.sv
// tb_slot_game_ctrl: randomized games against a credit/fever-window model with a scoreboard monitor
module tb_slot_game_ctrl;
  import slot_game_ctrl_pkg::*;
  localparam int FC = 20;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  slot_game_ctrl_if bus();
  slot_game_ctrl #(.TMR_W(24), .FEVER_CYCLES(FC)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;
  int checks = 0;
  int passes = 0;
  typedef struct {
    int credit;
    bit win;
    logic [11:0] ss;
    int at;
  } end_t;
  end_t end_q[$];
  int start_q[$];
  int win_q[$];
  int credit_m = 3;
  int last_v = 0;
  bit prev_ms = 1'b0;

  function automatic bit in_fever(int c);
    foreach (win_q[i]) if (c >= win_q[i] && c < win_q[i] + FC) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, got, exp, cyc);
  endtask

  // monitor: fever every cycle, scoreboard pops on game start and game end
  always @(negedge clock) begin
    if (!reset_n) prev_ms = 1'b0;
    else begin
      chk("fever", bus.fever, in_fever(cyc));
      if (bus.master_state && !prev_ms) begin
        chk("sb_start_expected", start_q.size() > 0, 1);
        if (start_q.size() > 0) begin
          int e;
          e = start_q.pop_front();
          chk("start_credit", bus.credit, e);
          chk("start_reel_run", bus.reel_run, 7);
        end
      end
      if (!bus.master_state && prev_ms) begin
        chk("sb_end_expected", end_q.size() > 0, 1);
        if (end_q.size() > 0) begin
          end_t e;
          e = end_q.pop_front();
          chk("end_credit", bus.credit, e.credit);
          chk("end_win", bus.win, e.win);
          chk("end_stop_sym", bus.stop_sym, e.ss);
          chk("end_latency", cyc, e.at);
        end
      end else chk("win_idle", bus.win, 0);
      prev_ms = bus.master_state;
    end
  end

  task automatic check_reset();
    chk("rst_reel_run", bus.reel_run, 0);
    chk("rst_master_state", bus.master_state, 0);
    chk("rst_fever", bus.fever, 0);
    chk("rst_credit", bus.credit, 3);
    chk("rst_win", bus.win, 0);
    chk("rst_stop_sym", bus.stop_sym, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset();
    credit_m = 3;
    win_q.delete();
    start_q.delete();
    end_q.delete();
    bus.start_pulse = 1'b0;
    bus.stop_pulse = '0;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic idle(bit spin);
    @(negedge clock);
    bus.start_pulse = spin ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.stop_pulse = '0;
    bus.reel_sym0 = 4'($urandom);
    bus.reel_sym1 = 4'($urandom);
    bus.reel_sym2 = 4'($urandom);
  endtask

  task automatic start_game(output bit ok);
    @(negedge clock);
    bus.start_pulse = 1'b1;
    bus.stop_pulse = '0;
    ok = in_fever(cyc) || credit_m != 0;
    if (ok) begin
      if (!in_fever(cyc)) credit_m--;
      start_q.push_back(credit_m);
    end
    @(negedge clock);
    bus.start_pulse = 1'b0;
  endtask

  task automatic play(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input int last_at, input bit all);
    bit ok;
    logic [2:0] left;
    logic [2:0] m;
    end_t e;
    int sum;
    start_game(ok);
    if (!ok) return;
    left = 3'b111;
    while (left != 0) begin
      repeat ($urandom_range(0, 2)) idle(1'b1);
      m = all ? 3'b111 : 3'($urandom_range(1, 7)) & left;
      if (m == 0) continue;
      if (last_at != 0 && m == left) while (cyc < last_at - 1) idle(1'b1);
      @(negedge clock);
      bus.start_pulse = 1'b0;
      bus.stop_pulse = m | (3'($urandom) & ~left);
      bus.reel_sym0 = m[0] ? a : 4'($urandom);
      bus.reel_sym1 = m[1] ? b : 4'($urandom);
      bus.reel_sym2 = m[2] ? c : 4'($urandom);
      left &= ~m;
    end
    e.win = a == b && b == c;
    if (e.win) begin
      sum = credit_m + (a == 7 ? 15 : 5);
      credit_m = sum > 255 ? 255 : sum;
      if (a == 7) begin
        win_q.push_back(cyc + 2);
        last_v = cyc + 2;
      end
    end
    e.credit = credit_m;
    e.ss = {c, b, a};
    e.at = cyc + 2;
    end_q.push_back(e);
    @(negedge clock);
    bus.stop_pulse = '0;
  endtask

  initial begin
    bit ok;
    logic [3:0] s;
    int r;
    bus.start_pulse = 1'b0;
    bus.stop_pulse = '0;
    bus.reel_sym0 = '0;
    bus.reel_sym1 = '0;
    bus.reel_sym2 = '0;
    do_reset();
    play(4'd2, 4'd2, 4'd2, 0, 1'b0);
    while (credit_m > 0) play(4'd1, 4'd2, 4'd3, 0, 1'b0);
    start_game(ok);
    repeat (3) idle(1'b0);
    chk("no_credit_master_state", bus.master_state, 0);
    chk("no_credit_reel_run", bus.reel_run, 0);
    chk("no_credit_credit", bus.credit, 0);
    do_reset();
    play(4'd7, 4'd7, 4'd7, 0, 1'b1);
    play(4'd4, 4'd5, 4'd6, 0, 1'b0);
    repeat (25) idle(1'b0);
    repeat (40) begin
      r = $urandom_range(0, 3);
      s = 4'($urandom);
      if (r < 2) play(r == 0 ? 4'd7 : s, r == 0 ? 4'd7 : s, r == 0 ? 4'd7 : s, 0, $urandom_range(0, 4) == 0);
      else play(4'($urandom), 4'($urandom), 4'($urandom), 0, $urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 3)) idle(1'b0);
    end
    do_reset();
    while (credit_m < 255) play(4'd7, 4'd7, 4'd7, 0, 1'b0);
    play(4'd7, 4'd7, 4'd7, last_v + 18, 1'b0);
    repeat (25) idle(1'b0);
    start_game(ok);
    @(negedge clock);
    bus.stop_pulse = 3'b101;
    @(negedge clock);
    bus.stop_pulse = '0;
    @(negedge clock);
    chk("mid_reel_run", bus.reel_run, 3'b010);
    chk("mid_master_state", bus.master_state, 1);
    do_reset();
    repeat (3) idle(1'b0);
    chk("scoreboard_drained", start_q.size() + end_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
